accum_sum7: RTL and testbench
=============================

# accum_sum7

Sequential accumulator that sits directly upstream-and-around the 7-bit ripple adder. It accepts a stream of 7-bit operands over a valid/ready handshake and adds each one to a running 7-bit accumulator through the combinational adder. It counts the adder carry-outs and, after a fixed batch of operands, presents the registered total on a valid/ready result port. It is the first clocked consumer of the adder's sum and carry outputs.

## Interface
- `WIDTH`, 7: operand and accumulator width.
- `N_OPS`, 4: operands per batch; legal range 1..15.
- `CW`, `$clog2(N_OPS+1)`: width of the carry counter; derived, not overridden.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous batch abort.
- `in_valid`  in  1  operand present.
- `in_ready`  out  1  block can accept an operand.
- `in_data`  in  WIDTH  operand.
- `in_ci`  in  1  carry-in applied to this operand's add.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  WIDTH  low WIDTH bits of the batch total.
- `out_cnt`  out  CW  number of adder carry-outs in the batch.
- `busy`  out  1  batch in progress (`op_cnt` != 0) or result pending.

## Operation
- The clock is `clk`. The reset is `rst_n`, asynchronous and active-low.
- States: `ACC` and `DONE`.
- Reset forces:
  - state to `ACC`
  - `acc`, `op_cnt`, `car_cnt` to 0
  - `out_valid`, `out_sum`, `out_cnt`, `busy` to 0
  - `in_ready` to 1
- `ACC` state:
  - `in_ready` = 1.
  - Accept occurs when `in_valid && in_ready && !clr`.
  - On accept: `{c, acc_next} = acc + in_data + in_ci` via the adder sub-module. `acc <= acc_next`, `car_cnt <= car_cnt + c`, `op_cnt <= op_cnt + 1`.
  - Each add produces at most one carry (max 127+127+1 = 255), so `car_cnt` never exceeds `N_OPS` and needs no saturation.
  - An accept with `op_cnt == N_OPS-1` moves the state to `DONE`. On that edge `out_sum <= acc_next`, `out_cnt <= car_cnt + c`, `out_valid <= 1`.
- `DONE` state:
  - `in_ready` = 0, and `in_valid` is ignored.
  - `out_sum` and `out_cnt` are held stable while `out_valid && !out_ready`.
  - When `out_ready` is high: `out_valid <= 0`, `acc`, `op_cnt`, `car_cnt` clear to 0, and the state returns to `ACC`.
- Exact batch total = `out_cnt * 2^WIDTH + out_sum`.
- `clr` (synchronous, highest priority after reset):
  - In `ACC`: clears `acc`, `op_cnt`, `car_cnt`. A simultaneous `in_valid` is not accepted (`in_ready` stays 1, but `clr` blocks the accept).
  - In `DONE`: drops the pending result (`out_valid <= 0`) and returns to `ACC`.
- Asserting `rst_n` low at any point, including mid-batch or in `DONE`, immediately returns every output to its reset value.

## Timing
- `in_ready` is a combinational decode of the state register only. It never depends on `in_valid`.
- Latency: `out_valid` rises on the clock edge that accepts the `N_OPS`-th operand, so it is visible in the following cycle.
- Minimum batch period is `N_OPS` + 1 cycles: `N_OPS` accepts plus one result handshake cycle. There is no accept in the same cycle as the result handshake.
- `in_ready` = 1 in the cycle after the result handshake.
- `out_sum`, `out_cnt`, `out_valid` are registered outputs. The adder path is the only combinational path (`acc` → `acc_next` → registers).

## Structure
- Shared package `sum_pkg`:
  - `WIDTH_DEF = 7`
  - state enum (`ACC`, `DONE`)
  - `N_OPS_MAX = 15`
- One sub-module: `rca_add`, a parameterised WIDTH-bit ripple-carry adder (a, b, ci → s, co), instantiated once. Its behaviour matches the existing 7-bit adder bit-for-bit.
- The top holds the FSM, counters and output registers.

## Test plan
All scenarios use `N_OPS` = 4.
1. **Reset:** assert `rst_n` = 0 mid-clock → `out_valid` = 0, `out_sum` = 0, `out_cnt` = 0, `busy` = 0, `in_ready` = 1 immediately, without waiting for a clock edge.
2. **Basic batch:** operands 1, 2, 5, 10 back-to-back, `in_ci` = 0 → `out_sum` = 7'b0010010 (18), `out_cnt` = 0. `out_valid` is high the cycle after the 4th accept. `in_ready` = 0 while `out_valid` is high.
3. **Carry counting:** operands 127, 127, 1, 0 with `in_ci` = 1 on each → `out_sum` = 3, `out_cnt` = 2. Total 2·128 + 3 = 259 = 255 + 4.
4. **Result backpressure:** hold `out_ready` = 0 for 5 cycles after `out_valid`, while driving `in_valid` = 1 with `in_data` = 7'h55 → `out_sum`/`out_cnt` stable, no operand accepted. Release `out_ready` → `out_valid` drops next cycle and `in_ready` = 1.
5. **Clear mid-batch:** accept 3, 4, then pulse `clr` together with `in_valid` (`in_data` = 9) → 9 not accepted. A following batch 1, 1, 1, 1 gives `out_sum` = 4, `out_cnt` = 0.
6. **Reset in `DONE`:** drop `rst_n` while `out_valid` = 1 → `out_valid` = 0 asynchronously. After release, a new batch 0, 0, 0, 0 with `in_ci` = 1 gives `out_sum` = 4.

Source files
------------

// File: rtl/accum_sum7_pkg.sv
// Shared definitions for the batch accumulator and its ripple adder.
package sum_pkg;

  localparam int WIDTH_DEF = 7;
  localparam int N_OPS_MAX = 15;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_e;

endpackage

// File: rtl/rca_add.sv
// Parameterised ripple-carry adder: s = a + b + ci, carry-out on co.
module rca_add #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  logic [WIDTH:0] carry;

  // Ripple the carry from bit 0 upwards, one full adder per bit
  always_comb begin
    carry    = '0;
    s        = '0;
    carry[0] = ci;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign co = carry[WIDTH];

endmodule

// File: rtl/accum_sum7.sv
// Batch accumulator: adds N_OPS operands through the ripple adder, counts
// carry-outs, and offers the registered batch total on a valid/ready port.
module accum_sum7
  import sum_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int N_OPS = 4,
  localparam int CW    = $clog2(N_OPS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CW-1:0]    out_cnt,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    op_cnt_q, op_cnt_d;
  logic [CW-1:0]    car_cnt_q, car_cnt_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic [CW-1:0]    out_cnt_q, out_cnt_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] acc_next;
  logic             add_co;
  logic             accept;
  logic [CW-1:0]    car_next;

  rca_add #(
    .WIDTH(WIDTH)
  ) u_add (
    .a  (acc_q),
    .b  (in_data),
    .ci (in_ci),
    .s  (acc_next),
    .co (add_co)
  );

  assign car_next = car_cnt_q + CW'(add_co);
  assign accept   = (state_q == ACC) && in_valid && !clr;

  // Next-state and register updates; clr outranks both accept and handshake
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    op_cnt_d    = op_cnt_q;
    car_cnt_d   = car_cnt_q;
    out_sum_d   = out_sum_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      ACC: begin
        if (clr) begin
          acc_d     = '0;
          op_cnt_d  = '0;
          car_cnt_d = '0;
        end else if (accept) begin
          acc_d     = acc_next;
          car_cnt_d = car_next;
          op_cnt_d  = op_cnt_q + CW'(1);
          if (op_cnt_q == CW'(N_OPS - 1)) begin
            state_d     = DONE;
            out_sum_d   = acc_next;
            out_cnt_d   = car_next;
            out_valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (clr || out_ready) begin
          state_d     = ACC;
          out_valid_d = 1'b0;
          acc_d       = '0;
          op_cnt_d    = '0;
          car_cnt_d   = '0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // State, accumulator, counters and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      op_cnt_q    <= '0;
      car_cnt_q   <= '0;
      out_sum_q   <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_cnt_q    <= op_cnt_d;
      car_cnt_q   <= car_cnt_d;
      out_sum_q   <= out_sum_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cnt   = out_cnt_q;
  assign busy      = (op_cnt_q != '0) || out_valid_q;

endmodule

// File: tb/tb_accum_sum7.sv
// Self-checking bench for accum_sum7 with a batch-total reference model.
module tb_accum_sum7;

  localparam int WIDTH = 7;
  localparam int N_OPS = 4;
  localparam int CW    = $clog2(N_OPS + 1);

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [CW-1:0]    out_cnt;
  logic             busy;

  int checks;
  int passes;

  // Reference model: batch progress and exact integer total of the batch
  bit mDone;
  int mCount;
  int mTotal;
  int mOutSum;
  int mOutCnt;

  accum_sum7 #(
    .WIDTH(WIDTH),
    .N_OPS(N_OPS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ci     (in_ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt),
    .busy      (busy)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and tally it
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp)
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    else
      passes++;
  endtask

  // Put the model back to its power-on condition
  task automatic modelReset();
    mDone   = 1'b0;
    mCount  = 0;
    mTotal  = 0;
    mOutSum = 0;
    mOutCnt = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at it
  task automatic modelStep();
    if (mDone) begin
      if (clr || out_ready) begin
        mDone  = 1'b0;
        mCount = 0;
        mTotal = 0;
      end
    end else if (clr) begin
      mCount = 0;
      mTotal = 0;
    end else if (in_valid) begin
      mTotal += int'(in_data) + int'(in_ci);
      mCount++;
      if (mCount == N_OPS) begin
        mDone   = 1'b1;
        mOutSum = mTotal % (1 << WIDTH);
        mOutCnt = mTotal / (1 << WIDTH);
      end
    end
  endtask

  // Compare every output against the model
  task automatic checkAll(input string where);
    checkOutput({where, ":out_valid"}, 32'(out_valid), 32'(mDone));
    checkOutput({where, ":in_ready"},  32'(in_ready),  32'(!mDone));
    checkOutput({where, ":busy"},      32'(busy),      32'((mCount != 0) || mDone));
    checkOutput({where, ":out_sum"},   32'(out_sum),   32'(mOutSum));
    checkOutput({where, ":out_cnt"},   32'(out_cnt),   32'(mOutCnt));
  endtask

  // Drive one cycle of inputs, clock it, then check outputs after the edge
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic ci,
                               input logic c, input logic ordy, input string where);
    in_valid  = v;
    in_data   = d;
    in_ci     = ci;
    clr       = c;
    out_ready = ordy;
    @(posedge clk);
    modelStep();
    #1;
    checkAll(where);
  endtask

  // Push a full batch back-to-back with a fixed carry-in
  task automatic runBatch(input int a, input int b, input int c, input int d,
                          input logic ci, input string where);
    int ops[4];
    ops = '{a, b, c, d};
    foreach (ops[k]) applyStimulus(1'b1, 7'(ops[k]), ci, 1'b0, 1'b0, where);
  endtask

  // Pull reset low between edges and check outputs without a clock
  task automatic asyncReset(input string where);
    #3;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll(where);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ci     = 1'b0;
    out_ready = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll("por");
    rst_n = 1'b1;

    // Reset mid-batch returns outputs immediately
    applyStimulus(1'b1, 7'd20, 1'b0, 1'b0, 1'b0, "pre_rst");
    applyStimulus(1'b1, 7'd30, 1'b0, 1'b0, 1'b0, "pre_rst");
    asyncReset("rst_mid");
    checkOutput("rst_mid_busy_const", 32'(busy), 32'd0);
    checkOutput("rst_mid_ready_const", 32'(in_ready), 32'd1);

    // Basic batch
    runBatch(1, 2, 5, 10, 1'b0, "basic");
    checkOutput("basic_sum_const", 32'(out_sum), 32'd18);
    checkOutput("basic_cnt_const", 32'(out_cnt), 32'd0);
    checkOutput("basic_valid_const", 32'(out_valid), 32'd1);
    checkOutput("basic_ready_const", 32'(in_ready), 32'd0);
    applyStimulus(1'b0, 7'd0, 1'b0, 1'b0, 1'b1, "basic_hs");

    // Carry counting
    runBatch(127, 127, 1, 0, 1'b1, "carry");
    checkOutput("carry_sum_const", 32'(out_sum), 32'd3);
    checkOutput("carry_cnt_const", 32'(out_cnt), 32'd2);

    // Result backpressure with operands offered meanwhile
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 7'h55, 1'b0, 1'b0, 1'b0, "bp_hold");
    checkOutput("bp_sum_const", 32'(out_sum), 32'd3);
    checkOutput("bp_cnt_const", 32'(out_cnt), 32'd2);
    applyStimulus(1'b1, 7'h55, 1'b0, 1'b0, 1'b1, "bp_release");
    checkOutput("bp_ready_const", 32'(in_ready), 32'd1);
    checkOutput("bp_busy_const", 32'(busy), 32'd0);

    // Clear mid-batch blocks a simultaneous operand
    applyStimulus(1'b1, 7'd3, 1'b0, 1'b0, 1'b0, "clr_pre");
    applyStimulus(1'b1, 7'd4, 1'b0, 1'b0, 1'b0, "clr_pre");
    applyStimulus(1'b1, 7'd9, 1'b0, 1'b1, 1'b0, "clr_pulse");
    checkOutput("clr_busy_const", 32'(busy), 32'd0);
    runBatch(1, 1, 1, 1, 1'b0, "clr_post");
    checkOutput("clr_sum_const", 32'(out_sum), 32'd4);
    checkOutput("clr_cnt_const", 32'(out_cnt), 32'd0);

    // Reset while a result is pending
    asyncReset("rst_done");
    checkOutput("rst_done_valid_const", 32'(out_valid), 32'd0);
    runBatch(0, 0, 0, 0, 1'b1, "rst_post");
    checkOutput("rst_post_sum_const", 32'(out_sum), 32'd4);
    applyStimulus(1'b0, 7'd0, 1'b0, 1'b0, 1'b1, "rst_post_hs");

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                    7'($urandom_range(0, 127)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                    1'($urandom_range(0, 1)),
                    "rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
